// File: rtl/uart_tx_ctrl.sv
// UART transmit frame controller: start, data (via external Serializer), optional parity, stop.
// One line bit per CLK; all outputs decode from registered state.
module uart_tx_ctrl #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  ser_data,
  input  logic                  ser_done,
  output logic                  ser_en,
  output logic                  busy,
  output logic                  TX_OUT,
  output logic                  frame_done,
  output logic                  sync_err
);

  localparam int unsigned CntW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] bit_cnt_q, bit_cnt_d;
  logic            par_bit_q, par_bit_d;
  logic            par_en_q, par_en_d;
  logic            sync_err_q, sync_err_d;
  logic            last_bit;

  assign last_bit = (bit_cnt_q == LastCnt);

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    par_bit_d  = par_bit_q;
    par_en_d   = par_en_q;
    sync_err_d = sync_err_q;
    unique case (state_q)
      StIdle: begin
        if (Data_Valid) begin
          state_d    = StStart;
          par_bit_d  = (^P_DATA) ^ PAR_TYP;
          par_en_d   = PAR_EN;
          sync_err_d = 1'b0;
          bit_cnt_d  = '0;
        end
      end
      StStart: state_d = StData;
      StData: begin
        // Leave on whichever of Serializer flag or own count fires first; disagreement is flagged.
        if (ser_done || last_bit) begin
          state_d   = par_en_q ? StParity : StStop;
          bit_cnt_d = '0;
          if (ser_done != last_bit) sync_err_d = 1'b1;
        end else begin
          bit_cnt_d = bit_cnt_q + CntW'(1);
        end
      end
      StParity: state_d = StStop;
      StStop:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= StIdle;
      bit_cnt_q  <= '0;
      par_bit_q  <= 1'b0;
      par_en_q   <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      par_bit_q  <= par_bit_d;
      par_en_q   <= par_en_d;
      sync_err_q <= sync_err_d;
    end
  end

  always_comb begin
    TX_OUT     = 1'b1;
    ser_en     = 1'b0;
    frame_done = 1'b0;
    busy       = (state_q != StIdle);
    unique case (state_q)
      StIdle:   TX_OUT = 1'b1;
      StStart:  TX_OUT = 1'b0;
      StData: begin
        TX_OUT = ser_data;
        ser_en = 1'b1;
      end
      StParity: TX_OUT = par_bit_q;
      StStop: begin
        TX_OUT     = 1'b1;
        frame_done = 1'b1;
      end
      default:  TX_OUT = 1'b1;
    endcase
  end

  assign sync_err = sync_err_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Scoreboard bench for uart_tx_ctrl: expected frames are queued at issue time and checked
// by a monitor that captures the line bit-by-bit while busy and compares at frame_done.
module tb_uart_tx_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] p_data = 8'h00;
  logic       data_valid = 1'b0;
  logic       par_en = 1'b0;
  logic       par_typ = 1'b0;
  logic       ser_data, ser_done;
  logic       ser_en, busy, tx_out, frame_done, sync_err;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic [15:0] bits;
    int          len;
    int          nd;
    logic        serr;
  } exp_t;
  exp_t sb[$];

  uart_tx_ctrl #(.DATA_WIDTH(8)) dut (
    .CLK       (clk),
    .RST       (rst),
    .P_DATA    (p_data),
    .Data_Valid(data_valid),
    .PAR_EN    (par_en),
    .PAR_TYP   (par_typ),
    .ser_data  (ser_data),
    .ser_done  (ser_done),
    .ser_en    (ser_en),
    .busy      (busy),
    .TX_OUT    (tx_out),
    .frame_done(frame_done),
    .sync_err  (sync_err)
  );

  always #5 clk = ~clk;

  // Serializer stand-in; ser_mode 0 normal, 1 done stuck low, 2 done at bit 3, 3 done high outside DATA
  logic [7:0] sh;
  int         scnt;
  int         ser_mode = 0;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sh   <= 8'h00;
      scnt <= 0;
    end else if (!busy) begin
      sh   <= p_data;
      scnt <= 0;
    end else if (ser_en) begin
      sh   <= sh >> 1;
      scnt <= scnt + 1;
    end
  end
  assign ser_data = sh[0];
  assign ser_done = (ser_mode == 0) ? (ser_en && scnt == 7) :
                    (ser_mode == 1) ? 1'b0 :
                    (ser_mode == 2) ? (ser_en && scnt == 3) :
                                      (!ser_en || scnt == 7);

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor
  logic [15:0] cap, scap;
  int          n_cap = 0;
  always @(negedge clk) begin
    exp_t        e;
    logic [15:0] sen;
    if (rst) begin
      n_cap = 0;
      cap   = '0;
      scap  = '0;
    end else if (busy) begin
      cap  = {cap[14:0], tx_out};
      scap = {scap[14:0], ser_en};
      n_cap++;
      if (frame_done) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_frame: got bits %0h len %0d, expected none", cap, n_cap);
        end else begin
          e   = sb.pop_front();
          sen = ((16'h1 << e.nd) - 16'h1) << (e.len - 1 - e.nd);
          check("frame_len", 16'(n_cap), 16'(e.len));
          check("frame_bits", cap, e.bits);
          check("ser_en_pattern", scap, sen);
          check("sync_err_at_stop", {15'b0, sync_err}, {15'b0, e.serr});
        end
        n_cap = 0;
        cap   = '0;
        scap  = '0;
      end
    end
  end

  task automatic issue(input logic [7:0] d, input logic pe, input logic pt, input logic push,
                       input logic [15:0] bits, input int len, input int nd, input logic serr);
    exp_t e;
    p_data     = d;
    par_en     = pe;
    par_typ    = pt;
    data_valid = 1'b1;
    if (push) begin
      e.bits = bits; e.len = len; e.nd = nd; e.serr = serr;
      sb.push_back(e);
    end
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (!busy && sb.size() == 0) done = 1;
    end
    if (!done) begin
      n_chk++;
      n_fail++;
      $display("FAIL wait_idle: got busy=%0b pending=%0d, expected idle", busy, sb.size());
    end
  endtask

  task automatic send(input logic [7:0] d, input logic pe, input logic pt,
                      input logic [15:0] bits, input int len, input int nd, input logic serr);
    issue(d, pe, pt, 1'b1, bits, len, nd, serr);
    @(negedge clk);
    data_valid = 1'b0;
    wait_idle();
  endtask

  initial begin
    bit seen;
    #2;
    check("reset_tx", {15'b0, tx_out}, 16'h1);
    check("reset_busy", {15'b0, busy}, 16'h0);
    check("reset_sync_err", {15'b0, sync_err}, 16'h0);
    @(negedge clk);
    rst = 1'b0;
    // 1: idle
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_line", {13'b0, tx_out, busy, ser_en}, 16'b100);
    end
    // 2: 0xA5 even parity
    send(8'hA5, 1'b1, 1'b0, 16'b01010010101, 11, 8, 1'b0);
    // 3: parity variants, config change mid-frame has no effect
    issue(8'h01, 1'b1, 1'b1, 1'b1, 16'b01000000001, 11, 8, 1'b0);
    @(negedge clk);
    data_valid = 1'b0;
    par_typ    = 1'b0;
    par_en     = 1'b0;
    wait_idle();
    send(8'h01, 1'b1, 1'b0, 16'b01000000011, 11, 8, 1'b0);
    send(8'h01, 1'b0, 1'b0, 16'b0100000001, 10, 8, 1'b0);
    // 4: Data_Valid held across frames
    issue(8'hA5, 1'b1, 1'b0, 1'b1, 16'b01010010101, 11, 8, 1'b0);
    issue(8'hA5, 1'b1, 1'b0, 1'b1, 16'b00011110001, 11, 8, 1'b0);
    @(negedge clk);
    p_data = 8'h3C;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (frame_done) seen = 1;
    end
    check("held_dv_first_stop", {15'b0, seen}, 16'h1);
    @(negedge clk);
    check("held_dv_idle_gap", {15'b0, busy}, 16'h0);
    @(negedge clk);
    check("held_dv_restart", {14'b0, busy, tx_out}, 16'b10);
    data_valid = 1'b0;
    wait_idle();
    // 5: reset during DATA bit 4
    issue(8'hA5, 1'b1, 1'b0, 1'b0, 16'h0, 0, 0, 1'b0);
    @(negedge clk);
    data_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("pre_reset_in_data", {15'b0, ser_en}, 16'h1);
    rst = 1'b1;
    #1;
    check("mid_reset_outputs", {13'b0, tx_out, busy, ser_en}, 16'b100);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send(8'h3C, 1'b0, 1'b0, 16'b0001111001, 10, 8, 1'b0);
    // 6: Serializer out of step
    ser_mode = 1;
    send(8'hA5, 1'b0, 1'b0, 16'b0101001011, 10, 8, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("sync_err_sticky", {15'b0, sync_err}, 16'h1);
    end
    ser_mode = 2;
    send(8'hA5, 1'b0, 1'b0, 16'b010101, 6, 4, 1'b1);
    ser_mode = 0;
    issue(8'h01, 1'b0, 1'b0, 1'b1, 16'b0100000001, 10, 8, 1'b0);
    @(negedge clk);
    data_valid = 1'b0;
    check("sync_err_cleared_on_accept", {15'b0, sync_err}, 16'h0);
    wait_idle();
    ser_mode = 3;
    send(8'h01, 1'b0, 1'b0, 16'b0100000001, 10, 8, 1'b0);
    repeat (3) @(negedge clk);
    check("sb_drained", 16'(sb.size()), 16'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
